// File: rtl/fetch_pipeline_ctrl.sv
// ============================================================================
// Module   : fetch_pipeline_ctrl
// Brief    : PC / IF-ID register owner with stall, flush, bubble and watchdog.
//            Optional perf counters are enabled by macro FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pipeline_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        id_ex_bubble,
  output logic        stall_error,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [4:0] MAX_STALL_W = 5'(MAX_STALL);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        active;
  logic [31:0] pc_plus4;
  logic [3:0]  run_cnt;
  logic [4:0]  run_cnt_inc;
  logic        unused_target_bits;

  assign active             = (state != BOOT);
  assign pc_plus4           = pc + 32'd4;
  assign run_cnt_inc        = {1'b0, run_cnt} + 5'd1;
  assign id_ex_bubble       = (stall & active) | ~if_id_valid;
  assign unused_target_bits = ^branch_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (stall)  state_nxt = HOLD;
      HOLD:    if (!stall) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Stall has priority: branch operands are not ready while a load-use stall is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      if_id_instr    <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (active && !stall) begin
      if (branch_flush) begin
        pc             <= {branch_target[31:2], 2'b00};
        if_id_instr    <= 32'd0;
        if_id_pc_plus4 <= 32'd0;
        if_id_valid    <= 1'b0;
      end else begin
        pc             <= pc_plus4;
        if_id_instr    <= imem_instr;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt     <= 4'd0;
      stall_error <= 1'b0;
    end else if (!stall) begin
      run_cnt <= 4'd0;
    end else if (active) begin
      if (run_cnt != 4'hF)            run_cnt     <= run_cnt_inc[3:0];
      if (run_cnt_inc > MAX_STALL_W)  stall_error <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else if (active) begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_flush && !stall && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_fetch_pipeline_ctrl
// Brief    : Scoreboard bench for fetch_pipeline_ctrl (FETCH_PERF_CNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_flush = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] imem_instr;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4, stall_count, flush_count;
  logic        if_id_valid, id_ex_bubble, stall_error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] pc, instr, pc4, sc, fc;
    logic        valid, bubble, err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Instruction memory tag: upper half constant, lower half the fetch address.
  assign imem_instr = {16'hA5A5, pc[15:0]};

  fetch_pipeline_ctrl #(.RESET_PC(32'h100), .MAX_STALL(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_flush(branch_flush),
    .branch_target(branch_target), .imem_instr(imem_instr), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble),
    .stall_error(stall_error), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
    end
  endtask

  // Expected values describe the cycle just before the next rising edge.
  task automatic cyc(input string name, input logic rn, input logic rst_mid,
                     input logic st, input logic fl, input logic [31:0] tgt,
                     input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                     input logic e_v, input logic e_b, input logic e_err,
                     input logic [31:0] e_sc, input logic [31:0] e_fc);
    exp_t e;
    @(negedge clk);
    rst_n = rn; stall = st; branch_flush = fl; branch_target = tgt;
    e.name = name; e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4;
    e.valid = e_v; e.bubble = e_b; e.err = e_err;
`ifdef FETCH_PERF_CNT_EN
    e.sc = e_sc; e.fc = e_fc;
`else
    e.sc = 32'd0; e.fc = 32'd0;
`endif
    sb.push_back(e);
    if (rst_mid) begin
      #2 rst_n = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.name, "pc",     pc,                    e.pc);
        chk(e.name, "instr",  if_id_instr,           e.instr);
        chk(e.name, "pc4",    if_id_pc_plus4,        e.pc4);
        chk(e.name, "valid",  {31'd0, if_id_valid},  {31'd0, e.valid});
        chk(e.name, "bubble", {31'd0, id_ex_bubble}, {31'd0, e.bubble});
        chk(e.name, "err",    {31'd0, stall_error},  {31'd0, e.err});
        chk(e.name, "scnt",   stall_count,           e.sc);
        chk(e.name, "fcnt",   flush_count,           e.fc);
      end
    end
  end

  initial begin : stimulus
    //  name       rn mid st fl target         pc            instr         pc4           v  b  e  sc fc
    cyc("reset",   0, 0, 0, 0, 32'h0,        32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 0);
    cyc("boot",    1, 0, 1, 1, 32'h400,      32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 0);
    cyc("run0",    1, 0, 0, 0, 32'h0,        32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 0);
    cyc("fetch1",  1, 0, 0, 1, 32'h1F,       32'h104,      32'hA5A50100, 32'h104,      1, 0, 0, 0, 0);
    cyc("flushA",  1, 0, 0, 0, 32'h0,        32'h1C,       32'h0,        32'h0,        0, 1, 0, 0, 1);
    cyc("lu_stall",1, 0, 1, 0, 32'h0,        32'h20,       32'hA5A5001C, 32'h20,       1, 1, 0, 0, 1);
    cyc("lu_held", 1, 0, 0, 0, 32'h0,        32'h20,       32'hA5A5001C, 32'h20,       1, 0, 0, 1, 1);
    cyc("resume",  1, 0, 0, 1, 32'h203,      32'h24,       32'hA5A50020, 32'h24,       1, 0, 0, 1, 1);
    cyc("br_flush",1, 0, 0, 0, 32'h0,        32'h200,      32'h0,        32'h0,        0, 1, 0, 1, 2);
    cyc("simul",   1, 0, 1, 1, 32'h400,      32'h204,      32'hA5A50200, 32'h204,      1, 1, 0, 1, 2);
    cyc("simul_h", 1, 0, 0, 0, 32'h0,        32'h204,      32'hA5A50200, 32'h204,      1, 0, 0, 2, 2);
    cyc("wd1",     1, 0, 1, 0, 32'h0,        32'h208,      32'hA5A50204, 32'h208,      1, 1, 0, 2, 2);
    cyc("wd2",     1, 0, 1, 0, 32'h0,        32'h208,      32'hA5A50204, 32'h208,      1, 1, 0, 3, 2);
    cyc("wd3",     1, 0, 1, 0, 32'h0,        32'h208,      32'hA5A50204, 32'h208,      1, 1, 0, 4, 2);
    cyc("wd4",     1, 0, 1, 0, 32'h0,        32'h208,      32'hA5A50204, 32'h208,      1, 1, 0, 5, 2);
    cyc("wd_err",  1, 0, 0, 0, 32'h0,        32'h208,      32'hA5A50204, 32'h208,      1, 0, 1, 6, 2);
    cyc("sticky",  1, 0, 0, 1, 32'hFFFFFFFF, 32'h20C,      32'hA5A50208, 32'h20C,      1, 0, 1, 6, 2);
    cyc("to_top",  1, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 32'h0,        32'h0,        0, 1, 1, 6, 3);
    cyc("wrap",    1, 0, 0, 0, 32'h0,        32'h0,        32'hA5A5FFFC, 32'h0,        1, 0, 1, 6, 3);
    cyc("hold_in", 1, 0, 1, 0, 32'h0,        32'h4,        32'hA5A50000, 32'h4,        1, 1, 1, 6, 3);
    cyc("async",   1, 1, 1, 1, 32'h400,      32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 0);
    cyc("in_rst",  0, 0, 0, 0, 32'h0,        32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 0);
    cyc("reboot",  1, 0, 0, 0, 32'h0,        32'h100,      32'h0,        32'h0,        0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
